ff_d_fifo: RTL and testbench

//   Small synchronous FIFO that sits directly upstream of the ff_d register stage.

---
 rtl/ff_d_fifo_if.sv | 45 ++++
 rtl/ff_d_fifo.sv | 125 ++++++++++++
 tb/tb_ff_d_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ff_d_fifo_if.sv
// ----------------------------------------------------------------------------
// ff_d_fifo_if
//   Producer/consumer bundle for ff_d_fifo. It groups the write side, the read
//   side, the flag-clear strobe and the status outputs into one port.
//   Signals:
//     i_wr_en, i_data   write request and write data
//     i_rd_en           read request
//     i_clr_flags       clears the sticky overflow/underflow flags
//     o_data, o_valid   registered read data and its 1-cycle update strobe
//     o_full, o_empty   occupancy flags
//     o_count           entries stored, 0..DEPTH
//     o_overflow        sticky: a write was dropped
//     o_underflow       sticky: a read was refused
//   Modports:
//     slave   the FIFO side (drives the o_* signals)
//     master  the producer/consumer side (drives the i_* signals)
// ----------------------------------------------------------------------------
interface ff_d_fifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_wr_en;
  logic [DW-1:0] i_data;
  logic          i_rd_en;
  logic          i_clr_flags;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_full;
  logic          o_empty;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_underflow;

  modport slave (
    input  i_wr_en, i_data, i_rd_en, i_clr_flags,
    output o_data, o_valid, o_full, o_empty, o_count, o_overflow, o_underflow
  );

  modport master (
    output i_wr_en, i_data, i_rd_en, i_clr_flags,
    input  o_data, o_valid, o_full, o_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/ff_d_fifo.sv
// ----------------------------------------------------------------------------
// ff_d_fifo
//   Small synchronous FIFO sitting directly upstream of the ff_d register
//   stage. It buffers bursty producer words and presents one word per
//   accepted read on o_data, which feeds ff_d.i_data. There is no
//   fall-through: a word appears on o_data one edge after its read is
//   accepted, and a word written at edge N is readable at edge N+1.
//   Ports:
//     clk   single clock, all state updates on the rising edge
//     rst   synchronous, active-high reset; overrides all other inputs
//     bus   ff_d_fifo_if.slave: write/read requests, flag clear, read data,
//           valid strobe, full/empty/count and sticky error flags
//   Parameters:
//     DW     data width (must match ff_d_pkg::t_dw)
//     DEPTH  number of entries, power of 2, >= 2
// ----------------------------------------------------------------------------
module ff_d_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  ff_d_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic [DW-1:0] data_q,   data_d;
  logic          valid_q,  valid_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;

  logic rd_acc;
  logic wr_acc;

  // A read is judged on pre-edge state; a write into a full FIFO is still
  // accepted when a read frees a slot on the same edge.
  assign rd_acc = bus.i_rd_en & ~empty_q;
  assign wr_acc = bus.i_wr_en & (~full_q | rd_acc);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; that is what keeps always_comb from inferring a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    // Pointers are exactly AW bits wide, so DEPTH being a power of 2 gives
    // the modulo wrap for free.
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);

    if (rd_acc) begin
      data_d   = mem[rd_ptr_q];
      valid_d  = 1'b1;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Sticky flags: a set event on the same edge as a clear wins.
    if (bus.i_wr_en & ~wr_acc)  ovf_d = 1'b1;
    else if (bus.i_clr_flags)   ovf_d = 1'b0;

    if (bus.i_rd_en & ~rd_acc)  udf_d = 1'b1;
    else if (bus.i_clr_flags)   udf_d = 1'b0;

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: storage has no reset; after reset the pointers and count make every
  // stale entry unreachable, so clearing it would only cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= bus.i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_full      = full_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_count     = count_q;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
endmodule

// File: tb/tb_ff_d_fifo.sv
// ----------------------------------------------------------------------------
// tb_ff_d_fifo
//   Self-checking bench for ff_d_fifo. A queue-based reference model tracks
//   what the FIFO must hold and output; a compare process checks every DUT
//   output against it on each falling edge, and the directed scenarios add
//   hand-computed literal expectations. A long randomized phase follows.
// ----------------------------------------------------------------------------
module tb_ff_d_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ff_d_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  ff_d_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_data;
  bit            m_valid;
  bit            m_ovf;
  bit            m_udf;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, then advance the
  // model from the pre-edge model state and the inputs just applied.
  task automatic step(input bit rs, input bit wr, input logic [DW-1:0] d,
                      input bit rd, input bit clr);
    bit rd_ok, wr_ok;
    rst             = rs;
    bus.i_wr_en     = wr;
    bus.i_data      = d;
    bus.i_rd_en     = rd;
    bus.i_clr_flags = clr;
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
      if (rd_ok) m_data = mq.pop_front();
      m_valid = rd_ok;
      if (wr_ok) mq.push_back(d);
      if (wr && !wr_ok) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      if (rd && !rd_ok) m_udf = 1'b1;
      else if (clr)     m_udf = 1'b0;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Continuous comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("data",      32'(bus.o_data),      32'(m_data));
      check("valid",     32'(bus.o_valid),     32'(m_valid));
      check("count",     32'(bus.o_count),     32'(mq.size()));
      check("full",      32'(bus.o_full),      32'(mq.size() == DEPTH));
      check("empty",     32'(bus.o_empty),     32'(mq.size() == 0));
      check("overflow",  32'(bus.o_overflow),  32'(m_ovf));
      check("underflow", 32'(bus.o_underflow), 32'(m_udf));
    end
  end

  initial begin
    logic [DW-1:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    // 1: reset for two edges with random inputs.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom));
    chk_en = 1'b1;
    check("rst_count",  32'(bus.o_count), 0);
    check("rst_empty",  32'(bus.o_empty), 1);
    check("rst_full",   32'(bus.o_full), 0);
    check("rst_data",   32'(bus.o_data), 0);
    check("rst_valid",  32'(bus.o_valid), 0);
    check("rst_flags",  32'({bus.o_overflow, bus.o_underflow}), 0);

    // 2: fill and drain.
    for (int i = 0; i < 4; i++) wr(seq[i]);
    check("fill_full",  32'(bus.o_full), 1);
    check("fill_count", 32'(bus.o_count), 4);
    for (int i = 0; i < 4; i++) begin
      rd();
      check("drain_data",  32'(bus.o_data), 32'(seq[i]));
      check("drain_valid", 32'(bus.o_valid), 1);
    end
    idle();
    check("drain_valid_low", 32'(bus.o_valid), 0);
    check("drain_empty",     32'(bus.o_empty), 1);

    // 3: overflow while full, dropped word never comes back, clear flag.
    for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i));
    wr(8'h55);
    check("ovf_count", 32'(bus.o_count), 4);
    check("ovf_flag",  32'(bus.o_overflow), 1);
    for (int i = 0; i < 4; i++) begin
      rd();
      check("ovf_drain", 32'(bus.o_data), 32'(8'hA1 + 8'(i)));
    end
    check("ovf_empty", 32'(bus.o_empty), 1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", 32'(bus.o_overflow), 0);

    // 4: underflow, then simultaneous write+read while empty.
    rd();
    check("udf_flag", 32'(bus.o_underflow), 1);
    check("udf_hold", 32'(bus.o_data), 32'(8'hA4));
    check("udf_nv",   32'(bus.o_valid), 0);
    step(1'b0, 1'b1, 8'h66, 1'b1, 1'b0);
    check("sim_count", 32'(bus.o_count), 1);
    check("sim_valid", 32'(bus.o_valid), 0);
    rd();
    check("sim_data",  32'(bus.o_data), 32'(8'h66));
    check("sim_valid2", 32'(bus.o_valid), 1);

    // 5: pointer wrap with write+read at count 2.
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    wr(8'hE0);
    wr(8'hE1);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, DW'(i), 1'b1, 1'b0);
      check("wrap_count", 32'(bus.o_count), 2);
      if (i == 1)      check("wrap_data", 32'(bus.o_data), 32'(8'hE0));
      else if (i == 2) check("wrap_data", 32'(bus.o_data), 32'(8'hE1));
      else             check("wrap_data", 32'(bus.o_data), 32'(i - 2));
    end
    check("wrap_flags", 32'({bus.o_overflow, bus.o_underflow}), 0);

    // 6: mid-operation reset at count 3.
    wr(8'h0B);
    check("mid_count", 32'(bus.o_count), 3);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    check("mid_rst_count", 32'(bus.o_count), 0);
    check("mid_rst_empty", 32'(bus.o_empty), 1);
    check("mid_rst_data",  32'(bus.o_data), 0);
    wr(8'h77);
    rd();
    check("mid_data", 32'(bus.o_data), 32'(8'h77));

    // Randomized traffic; bias shifts between phases to reach full and empty.
    for (int p = 0; p < 8; p++) begin
      int wr_pct = (p % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 300; i++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < wr_pct),
             DW'($urandom),
             ($urandom_range(0, 99) < (100 - wr_pct)),
             ($urandom_range(0, 19) == 0));
      end
    end

    idle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
